add_sched: RTL
==============

ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the 3-operand adder; fixed at 4 in this revision.
REQ-002 Parameter IDW, default 2, width of requester index (clog2 NREQ).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester request; bit i = requester i.
REQ-006 opa  input  NREQ  operand a bit of requester i at bit i.
REQ-007 opb  input  NREQ  operand b bit of requester i at bit i.
REQ-008 opc  input  NREQ  operand c bit of requester i at bit i.
REQ-009 gnt  output  NREQ  registered one-hot grant; operands captured on the edge that raises it.
REQ-010 res_vld  output  1  result valid.
REQ-011 res  output  2  result = a + b + c of the granted triple.
REQ-012 res_id  output  IDW  index of the requester owning res.
REQ-013 res_rdy  input  1  downstream accepts res when res_vld & res_rdy.

Function
REQ-014 Pipeline SHALL have three stages: S0 arbitrate/capture, S1 d = a + b (2-bit), S2 res = d + c (2-bit); max value 3, no overflow.
REQ-015 Request sampled high at edge E (and granted) SHALL give gnt high in the cycle after E and res_vld with matching res/res_id 3 cycles after E, absent stalls.
REQ-016 Throughput SHALL be one grant per cycle across requesters.
REQ-017 Arbitration SHALL be round-robin: search starts at ptr, ascending with wrap NREQ-1 -> 0; ptr becomes winner+1 mod NREQ after each grant.
REQ-018 A requester whose gnt bit is high in the current cycle SHALL be masked at that edge; a continuously requesting requester is granted at most every other cycle.
REQ-019 Requester SHALL treat gnt as consumption of its operands; keeping req high requests another operation.
REQ-020 No eligible request SHALL give gnt = 0, ptr unchanged, and an empty bubble into S1.
REQ-021 Stall: when res_vld & !res_rdy, all stages, ptr, res, res_id SHALL hold, and no new grant SHALL issue (gnt = 0 next cycle).
REQ-022 Bubbles SHALL collapse: an empty S2 or S1 SHALL advance even while a downstream stage is stalled only if the stage ahead of it is empty.
REQ-023 res_vld & res_rdy with an incoming valid from S1 SHALL replace the result in the same edge (no bubble).
REQ-024 Simultaneous requests from all requesters SHALL be served in ptr order, one per cycle, subject to REQ-018.

Reset
REQ-025 Rst high at an edge SHALL clear gnt = 0, res_vld = 0, res = 0, res_id = 0, ptr = 0, and all stage valid bits.
REQ-026 Rst mid-operation SHALL discard in-flight results; no res_vld until a fresh grant completes the pipeline.
REQ-027 First edge after Rst deasserts SHALL arbitrate normally.

Structure
REQ-028 Shared package add_sched_pkg SHALL hold NREQ, IDW, pipeline latency constant LAT = 3, and the stage record type (valid, id, a, b, c / d).
REQ-029 Round-robin selection SHALL be a sub-module rr_arb (inputs req, mask, ptr; outputs one-hot win, win index, any).
REQ-030 Adder stages SHALL be inline in add_sched.

Verification
REQ-031 Single req: req = 0010, opa/opb/opc bit1 = 1/1/1, res_rdy = 1 -> gnt = 0010 next cycle, res_vld with res = 3, res_id = 1, 3 cycles after sample.
REQ-032 All request, ptr = 0, req = 1111 held, res_rdy = 1 -> grant sequence 0001, 0010, 0100, 1000, 0001 ... ; res_id 0,1,2,3 back-to-back.
REQ-033 Single continuous requester req = 0100 -> gnt toggles 0100/0000; res_vld every other cycle.
REQ-034 Stall: res_rdy = 0 for 4 cycles with 3 ops in flight -> res/res_id held stable, gnt = 0, no op lost or duplicated after res_rdy = 1.
REQ-035 Rst asserted one cycle with 2 ops in flight -> res_vld = 0, gnt = 0, ptr = 0 next cycle; no stale result emerges.
REQ-036 Random req/operand/res_rdy for 10k cycles -> scoreboard: every grant yields exactly one result, res = a+b+c, in grant order.

Source files
------------

// File: rtl/add_sched_pkg.sv
// ============================================================================
// Module  : add_sched_pkg
// Brief   : Shared constants and pipeline stage records for add_sched.
// Revision: 1.0
// ============================================================================
`default_nettype none

package add_sched_pkg;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 3;

    // Arbitration/capture stage: raw operand bits of the granted requester
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           a;
        logic           b;
        logic           c;
    } s0_rec_t;

    // First adder stage: partial sum d = a + b, c carried forward
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic [1:0]     d;
        logic           c;
    } s1_rec_t;

endpackage

`default_nettype wire

// File: rtl/add_sched_rr_arb.sv
// ============================================================================
// Module  : rr_arb
// Brief   : Round-robin selector, ascending search from ptr with wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb
    import add_sched_pkg::*;
#(
    parameter int NREQ = add_sched_pkg::NREQ,
    parameter int IDW  = add_sched_pkg::IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win,
    output logic [IDW-1:0]  win_idx,
    output logic            any
);

    logic [NREQ-1:0] w_elig;
    logic [IDW-1:0]  w_j;

    assign w_elig = req & ~mask;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Index arithmetic wraps modulo NREQ because NREQ == 2**IDW
            w_j = ptr + IDW'(k);
            if (!any && w_elig[w_j]) begin
                any      = 1'b1;
                win_idx  = w_j;
                win[w_j] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/add_sched.sv
// ============================================================================
// Module  : add_sched
// Brief   : Round-robin scheduler sharing a pipelined 3-operand 1-bit adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_sched
    import add_sched_pkg::*;
#(
    parameter int NREQ = add_sched_pkg::NREQ,
    parameter int IDW  = add_sched_pkg::IDW
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] opa,
    input  logic [NREQ-1:0] opb,
    input  logic [NREQ-1:0] opc,
    output logic [NREQ-1:0] gnt,
    output logic            res_vld,
    output logic [1:0]      res,
    output logic [IDW-1:0]  res_id,
    input  logic            res_rdy
);

    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_ptr;
    s0_rec_t         r_s0;
    s1_rec_t         r_s1;
    logic            r_res_vld;
    logic [1:0]      r_res;
    logic [IDW-1:0]  r_res_id;

    logic [NREQ-1:0] w_win;
    logic [IDW-1:0]  w_win_idx;
    logic            w_any;
    logic            w_stall;
    logic            w_s1_en;
    logic            w_s0_en;
    logic [1:0]      w_d;
    logic [1:0]      w_sum;

    // A stage may load whenever it is empty or the stage ahead is moving
    assign w_stall = r_res_vld & ~res_rdy;
    assign w_s1_en = ~r_s1.valid | ~w_stall;
    assign w_s0_en = ~r_s0.valid | w_s1_en;

    assign w_d   = {1'b0, r_s0.a} + {1'b0, r_s0.b};
    assign w_sum = r_s1.d + {1'b0, r_s1.c};

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req),
        .mask    (r_gnt),
        .ptr     (r_ptr),
        .win     (w_win),
        .win_idx (w_win_idx),
        .any     (w_any)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_s0      <= '0;
            r_s1      <= '0;
            r_res_vld <= 1'b0;
            r_res     <= '0;
            r_res_id  <= '0;
        end else begin
            if (w_stall) begin
                // No grant while the output is blocked; s0 may only drain forward
                r_gnt <= '0;
                if (w_s0_en) begin
                    r_s0.valid <= 1'b0;
                end
            end else begin
                r_gnt      <= w_win;
                r_s0.valid <= w_any;
                r_s0.id    <= w_win_idx;
                r_s0.a     <= |(opa & w_win);
                r_s0.b     <= |(opb & w_win);
                r_s0.c     <= |(opc & w_win);
                if (w_any) begin
                    r_ptr <= w_win_idx + IDW'(1);
                end
            end

            if (w_s1_en) begin
                r_s1.valid <= r_s0.valid;
                r_s1.id    <= r_s0.id;
                r_s1.d     <= w_d;
                r_s1.c     <= r_s0.c;
            end

            if (!w_stall) begin
                r_res_vld <= r_s1.valid;
                if (r_s1.valid) begin
                    r_res    <= w_sum;
                    r_res_id <= r_s1.id;
                end
            end
        end
    end

    assign gnt     = r_gnt;
    assign res_vld = r_res_vld;
    assign res     = r_res;
    assign res_id  = r_res_id;

endmodule

`default_nettype wire
